// File: rtl/tmr_pkg.sv
// Shared definitions for the TMR source path.
// Holds the lane index constants used on the injection port and the
// encoding of each lane's health FSM.
package tmr_pkg;

  localparam logic [1:0] LANE_A    = 2'd0;
  localparam logic [1:0] LANE_B    = 2'd1;
  localparam logic [1:0] LANE_C    = 2'd2;
  localparam logic [1:0] LANE_NONE = 2'd3;

  typedef enum logic [1:0] {
    OK      = 2'd0,
    SUSPECT = 2'd1,
    FAILED  = 2'd2
  } health_e;

endpackage

// File: rtl/tmr_lane_health.sv
// Per-lane health tracker. It counts consecutive cycles in which the lane
// disagrees with the vote, and latches FAILED (sticky until reset) once the
// run reaches FAIL_THRESH.
// Ports:
//   clock      rising-edge clock
//   reset_n_in synchronous active-low reset
//   mis_x      lane disagrees with the majority this cycle
//   failed_x   lane has been declared failed (registered, sticky)
module tmr_lane_health
  import tmr_pkg::*;
#(
  parameter int unsigned FAIL_THRESH = 4
) (
  input  logic clock,
  input  logic reset_n_in,
  input  logic mis_x,
  output logic failed_x
);

  // The counter only ever has to hold values up to FAIL_THRESH-1.
  localparam int unsigned CW = (FAIL_THRESH > 2) ? $clog2(FAIL_THRESH) : 1;

  health_e       state, state_nxt;
  logic [CW-1:0] consec, consec_nxt;

  // State and run-length registers
  always_ff @(posedge clock) begin
    if (!reset_n_in) begin
      state    <= OK;
      consec   <= '0;
      failed_x <= 1'b0;
    end else begin
      state    <= state_nxt;
      consec   <= consec_nxt;
      failed_x <= (state_nxt == FAILED);
    end
  end

  // Next-state logic; the edge that sees the last tolerated mismatch fails the lane
  always_comb begin
    state_nxt  = state;
    consec_nxt = consec;
    case (state)
      OK, SUSPECT: begin
        if (mis_x) begin
          if (consec == CW'(FAIL_THRESH - 1)) begin
            state_nxt = FAILED;
          end else begin
            state_nxt  = SUSPECT;
            consec_nxt = consec + CW'(1);
          end
        end else begin
          state_nxt  = OK;
          consec_nxt = '0;
        end
      end
      FAILED: begin
        state_nxt = FAILED;
      end
      default: begin
        state_nxt  = OK;
        consec_nxt = '0;
      end
    endcase
  end

endmodule

// File: rtl/tmr_triplicator.sv
// Source side of the TMR path: three copy registers of one value, a bitwise
// 2-of-3 vote, scrub-on-disagreement, per-lane health tracking, a saturating
// scrub counter and a test-only fault-injection port.
// Ports:
//   clock, reset_n_in          clock and synchronous active-low reset
//   d_in, load_in              value loaded into all lanes
//   inject_lane_in/mask_in     lane (3 = none) and bits XORed into its next value
//   a_out/b_out/c_out          lane registers
//   v_out                      majority of the lanes (from registers)
//   mismatch_out               some lane differs from v_out
//   lane_failed_out            sticky per-lane failure flags
//   fatal_out                  two or more lanes failed
//   scrub_count_out            saturating count of mismatch cycles
module tmr_triplicator
  import tmr_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned FAIL_THRESH = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset_n_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load_in,
  input  logic [1:0]       inject_lane_in,
  input  logic [WIDTH-1:0] inject_mask_in,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic [WIDTH-1:0] c_out,
  output logic [WIDTH-1:0] v_out,
  output logic             mismatch_out,
  output logic [2:0]       lane_failed_out,
  output logic             fatal_out,
  output logic [CNT_W-1:0] scrub_count_out
);

  logic [2:0]       mis;
  logic [WIDTH-1:0] base_nxt;
  logic [WIDTH-1:0] a_nxt, b_nxt, c_nxt;

  // Vote and per-lane disagreement
  always_comb begin
    v_out        = (a_out & b_out) | (b_out & c_out) | (a_out & c_out);
    mis[0]       = |(a_out ^ v_out);
    mis[1]       = |(b_out ^ v_out);
    mis[2]       = |(c_out ^ v_out);
    mismatch_out = |mis;
  end

  // Load beats scrub beats hold; injection is applied on top of the chosen value.
  // When nothing is loaded or scrubbed all lanes agree, so v_out is the held value.
  always_comb begin
    base_nxt = load_in ? d_in : v_out;
    a_nxt    = (load_in || mismatch_out) ? base_nxt : a_out;
    b_nxt    = (load_in || mismatch_out) ? base_nxt : b_out;
    c_nxt    = (load_in || mismatch_out) ? base_nxt : c_out;
    if (inject_lane_in == LANE_A) a_nxt = a_nxt ^ inject_mask_in;
    if (inject_lane_in == LANE_B) b_nxt = b_nxt ^ inject_mask_in;
    if (inject_lane_in == LANE_C) c_nxt = c_nxt ^ inject_mask_in;
  end

  // Lane registers and scrub counter
  always_ff @(posedge clock) begin
    if (!reset_n_in) begin
      a_out           <= '0;
      b_out           <= '0;
      c_out           <= '0;
      scrub_count_out <= '0;
    end else begin
      a_out <= a_nxt;
      b_out <= b_nxt;
      c_out <= c_nxt;
      if (mismatch_out && (scrub_count_out != '1)) begin
        scrub_count_out <= scrub_count_out + CNT_W'(1);
      end
    end
  end

  tmr_lane_health #(.FAIL_THRESH(FAIL_THRESH)) u_health_a (
    .clock      (clock),
    .reset_n_in (reset_n_in),
    .mis_x      (mis[0]),
    .failed_x   (lane_failed_out[0])
  );

  tmr_lane_health #(.FAIL_THRESH(FAIL_THRESH)) u_health_b (
    .clock      (clock),
    .reset_n_in (reset_n_in),
    .mis_x      (mis[1]),
    .failed_x   (lane_failed_out[1])
  );

  tmr_lane_health #(.FAIL_THRESH(FAIL_THRESH)) u_health_c (
    .clock      (clock),
    .reset_n_in (reset_n_in),
    .mis_x      (mis[2]),
    .failed_x   (lane_failed_out[2])
  );

  // Two or more failed lanes leaves no trustworthy majority
  always_comb begin
    fatal_out = (lane_failed_out[0] & lane_failed_out[1]) |
                (lane_failed_out[1] & lane_failed_out[2]) |
                (lane_failed_out[0] & lane_failed_out[2]);
  end

endmodule
